// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: issues per-pixel requests to the compositor and
// re-aligns the returned pixel with HS/VS/DE on the pin-side output registers.
module vga_timing_gen #(
    parameter int   H_ACTIVE = 1024,
    parameter int   H_FP     = 24,
    parameter int   H_SYNC   = 136,
    parameter int   H_BP     = 160,
    parameter int   V_ACTIVE = 768,
    parameter int   V_FP     = 3,
    parameter int   V_SYNC   = 6,
    parameter int   V_BP     = 29,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   PIPE_DLY = 2
) (
    input  logic        VGA_CLK,
    input  logic        RST_N,
    input  logic [23:0] VGA_BUF_RGB,
    output logic        VGA_IF_RGBEN,
    output logic        FRAME_START,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_DE,
    output logic [23:0] VGA_RGB
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_ACT      = 12'(H_ACTIVE);
    localparam logic [11:0] V_ACT      = 12'(V_ACTIVE);
    localparam logic [11:0] H_SYNC_ON  = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] H_SYNC_OFF = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] V_SYNC_ON  = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] V_SYNC_OFF = 12'(V_ACTIVE + V_FP + V_SYNC);

    // Stage word layout: {de, hs, vs}; idle means no data and both syncs inactive.
    localparam logic [2:0] IDLE_STG = {1'b0, ~HS_POL, ~VS_POL};

    logic [11:0] h_cnt_reg;
    logic [11:0] v_cnt_reg;
    logic [2:0]  stg_reg [0:PIPE_DLY];
    logic        frame_start_reg;
    logic [23:0] rgb_reg;

    logic        de_next;
    logic        hs_next;
    logic        vs_next;
    logic        fs_next;

    always_comb begin
        de_next = (h_cnt_reg < H_ACT) && (v_cnt_reg < V_ACT);
        hs_next = ((h_cnt_reg >= H_SYNC_ON) && (h_cnt_reg < H_SYNC_OFF)) ? HS_POL : ~HS_POL;
        vs_next = ((v_cnt_reg >= V_SYNC_ON) && (v_cnt_reg < V_SYNC_OFF)) ? VS_POL : ~VS_POL;
        fs_next = (h_cnt_reg == 12'd0) && (v_cnt_reg == 12'd0);
    end

    always_ff @(posedge VGA_CLK) begin
        if (!RST_N) begin
            h_cnt_reg       <= '0;
            v_cnt_reg       <= '0;
            frame_start_reg <= 1'b0;
            rgb_reg         <= '0;
            for (int i = 0; i <= PIPE_DLY; i++) begin
                stg_reg[i] <= IDLE_STG;
            end
        end else begin
            if (h_cnt_reg == H_LAST) begin
                h_cnt_reg <= '0;
                v_cnt_reg <= (v_cnt_reg == V_LAST) ? 12'd0 : v_cnt_reg + 12'd1;
            end else begin
                h_cnt_reg <= h_cnt_reg + 12'd1;
            end

            stg_reg[0]      <= {de_next, hs_next, vs_next};
            frame_start_reg <= fs_next;
            for (int i = 1; i <= PIPE_DLY; i++) begin
                stg_reg[i] <= stg_reg[i-1];
            end

            // Pixel is captured one stage ahead of the pins so it lands with its DE.
            rgb_reg <= stg_reg[PIPE_DLY-1][2] ? VGA_BUF_RGB : 24'h0;
        end
    end

    assign VGA_IF_RGBEN = stg_reg[0][2];
    assign FRAME_START  = frame_start_reg;
    assign VGA_DE       = stg_reg[PIPE_DLY][2];
    assign VGA_HS       = stg_reg[PIPE_DLY][1];
    assign VGA_VS       = stg_reg[PIPE_DLY][0];
    assign VGA_RGB      = rgb_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 1024x768 instance plus a tiny-raster instance,
// checked every cycle against an arithmetic raster model and directed line/frame measurements.
module tb_vga_timing_gen;

    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
        logic fs;
    } tim_t;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Default-timing instance
    logic        rst_n_d = 1'b1;
    logic [23:0] buf_d = 24'hFFFFFF;
    logic        en_d, fs_d, hs_d, vs_d, de_d;
    logic [23:0] rgb_d;

    // Small-raster instance
    logic        rst_n_s = 1'b1;
    logic [23:0] buf_s;
    logic        en_s, fs_s, hs_s, vs_s, de_s;
    logic [23:0] rgb_s;

    vga_timing_gen u_dut (
        .VGA_CLK(clk), .RST_N(rst_n_d), .VGA_BUF_RGB(buf_d),
        .VGA_IF_RGBEN(en_d), .FRAME_START(fs_d), .VGA_HS(hs_d), .VGA_VS(vs_d),
        .VGA_DE(de_d), .VGA_RGB(rgb_d)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .PIPE_DLY(1)
    ) u_small (
        .VGA_CLK(clk), .RST_N(rst_n_s), .VGA_BUF_RGB(buf_s),
        .VGA_IF_RGBEN(en_s), .FRAME_START(fs_s), .VGA_HS(hs_s), .VGA_VS(vs_s),
        .VGA_DE(de_s), .VGA_RGB(rgb_s)
    );

    int tests = 0;
    int fails = 0;

    // Raster model: stage-0 view after j clock edges since the reset edge (j=0 is the reset edge).
    function automatic tim_t s0(input int j, input int ha, input int hfp, input int hsy, input int hbp,
                                input int va, input int vfp, input int vsy, input int vbp);
        tim_t r;
        int ht, vt, idx, h, v;
        r = '{de: 1'b0, hs: 1'b1, vs: 1'b1, fs: 1'b0};
        if (j <= 0) return r;
        ht  = ha + hfp + hsy + hbp;
        vt  = va + vfp + vsy + vbp;
        idx = (j - 1) % (ht * vt);
        h   = idx % ht;
        v   = idx / ht;
        r.de = (h < ha) && (v < va);
        r.hs = !((h >= ha + hfp) && (h < ha + hfp + hsy));
        r.vs = !((v >= va + vfp) && (v < va + vfp + vsy));
        r.fs = (idx == 0);
        return r;
    endfunction

    function automatic tim_t md(input int j);
        return s0(j, 1024, 24, 136, 160, 768, 3, 6, 29);
    endfunction

    function automatic tim_t ms(input int j);
        return s0(j, 8, 2, 3, 2, 4, 1, 2, 1);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            if (fails <= 40)
                $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Edge counters since the most recent reset edge, and the input each DUT captured.
    int          k_d = 0, k_s = 0, cyc = 0;
    logic        valid_d = 1'b0, valid_s = 1'b0;
    logic [23:0] cap_d = '0, cap_s = '0;
    logic [23:0] px_d = '0;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        cap_d <= buf_d;
        cap_s <= buf_s;
        if (!rst_n_d) begin k_d <= 0; valid_d <= 1'b1; end else k_d <= k_d + 1;
        if (!rst_n_s) begin k_s <= 0; valid_s <= 1'b1; end else k_s <= k_s + 1;
        // Compositor stand-in: per-line pixel index, one register behind the request.
        buf_d <= en_d ? px_d : 24'hFFFFFF;
        px_d  <= en_d ? px_d + 24'd1 : 24'd0;
    end

    assign buf_s = en_s ? {12'h5A0, cyc[11:0]} : 24'hFFFFFF;

    // Measurement state
    int   en_rise_t = -1, en_fall_t = -1, de_rise_t = -1, hs_fall_t = -1, run_d = 0;
    int   fs_t_s = -1, en_cnt_s = 0, vs_fall_t_s = -1;
    int   n_lines = 0, n_frames = 0;
    logic en_p = 1'b0, de_p = 1'b0, hs_p = 1'b1, fs_p_s = 1'b0, vs_p_s = 1'b1;
    logic end_chk = 1'b0;
    tim_t e0, eo;

    always @(negedge clk) begin
        if (cyc == 1) begin
            // Hand-computed points that pin the model itself
            e0 = md(1);                chk("model_d_first_px", {e0.de, e0.fs, e0.hs, e0.vs}, 4'b1111);
            e0 = md(1025);             chk("model_d_px1024_de", e0.de, 0);
            e0 = md(1048);             chk("model_d_h1047_hs", e0.hs, 1);
            e0 = md(1049);             chk("model_d_h1048_hs", e0.hs, 0);
            e0 = md(1185);             chk("model_d_h1184_hs", e0.hs, 1);
            e0 = md(771 * 1344 + 1);   chk("model_d_l771_vs", e0.vs, 0);
            e0 = md(771 * 1344);       chk("model_d_l770_vs", e0.vs, 1);
            e0 = md(777 * 1344 + 1);   chk("model_d_l777_vs", e0.vs, 1);
            e0 = md(1083264 + 1);      chk("model_d_frame_wrap", e0.fs, 1);
            e0 = ms(10);               chk("model_s_h9_hs", e0.hs, 1);
            e0 = ms(11);               chk("model_s_h10_hs", e0.hs, 0);
            e0 = ms(13);               chk("model_s_h12_hs", e0.hs, 0);
            e0 = ms(14);               chk("model_s_h13_hs", e0.hs, 1);
            e0 = ms(5 * 15 + 1);       chk("model_s_l5_vs", e0.vs, 0);
            e0 = ms(7 * 15);           chk("model_s_l6_vs", e0.vs, 0);
            e0 = ms(7 * 15 + 1);       chk("model_s_l7_vs", e0.vs, 1);
            e0 = ms(121);              chk("model_s_wrap", {e0.fs, e0.de}, 2'b11);
        end

        if (valid_d) begin
            e0 = md(k_d);
            eo = md(k_d - 2);
            chk("d_rgben", en_d, e0.de);
            chk("d_frame_start", fs_d, e0.fs);
            chk("d_de", de_d, eo.de);
            chk("d_hs", hs_d, eo.hs);
            chk("d_vs", vs_d, eo.vs);
            chk("d_rgb", rgb_d, eo.de ? cap_d : 24'h0);
            if (k_d == 0) begin
                chk("d_rst_outputs", {en_d, fs_d, de_d, hs_d, vs_d}, 5'b00011);
                chk("d_rst_rgb", rgb_d, 0);
                en_rise_t = -1; en_fall_t = -1; de_rise_t = -1; hs_fall_t = -1; run_d = 0;
            end
            if (k_d == 1) chk("d_first_req", {en_d, fs_d}, 2'b11);

            if (de_d) begin
                chk("d_pixel_align", rgb_d, run_d);
                run_d++;
            end else begin
                run_d = 0;
            end

            if (k_d > 0) begin
                if (en_d && !en_p) begin
                    if (en_fall_t >= 0) chk("d_rgben_low_len", k_d - en_fall_t, 320);
                    en_rise_t = k_d;
                end
                if (!en_d && en_p && en_rise_t >= 0) begin
                    chk("d_rgben_high_len", k_d - en_rise_t, 1024);
                    en_fall_t = k_d;
                end
                if (de_d && !de_p) de_rise_t = k_d;
                if (!hs_d && hs_p) begin
                    if (de_rise_t >= 0) chk("d_de_to_hs_fall", k_d - de_rise_t, 1048);
                    if (hs_fall_t >= 0) begin
                        chk("d_line_period", k_d - hs_fall_t, 1344);
                        n_lines++;
                        $display("[TB] line %0d: HS period %0d clks", n_lines, k_d - hs_fall_t);
                    end
                    hs_fall_t = k_d;
                    de_rise_t = -1;
                end
                if (hs_d && !hs_p && hs_fall_t >= 0) chk("d_hs_low_len", k_d - hs_fall_t, 136);
            end
            en_p = en_d; de_p = de_d; hs_p = hs_d;
        end

        if (valid_s) begin
            e0 = ms(k_s);
            eo = ms(k_s - 1);
            chk("s_rgben", en_s, e0.de);
            chk("s_frame_start", fs_s, e0.fs);
            chk("s_de", de_s, eo.de);
            chk("s_hs", hs_s, eo.hs);
            chk("s_vs", vs_s, eo.vs);
            chk("s_rgb", rgb_s, eo.de ? cap_s : 24'h0);
            if (k_s == 0) begin
                chk("s_rst_outputs", {en_s, fs_s, de_s, hs_s, vs_s}, 5'b00011);
                fs_t_s = -1; vs_fall_t_s = -1; en_cnt_s = 0;
            end
            if (k_s > 0) begin
                if (fs_s && !fs_p_s) begin
                    if (fs_t_s >= 0) begin
                        chk("s_frame_period", k_s - fs_t_s, 120);
                        chk("s_rgben_per_frame", en_cnt_s, 32);
                        n_frames++;
                        $display("[TB] small frame %0d: period %0d clks, %0d requests",
                                 n_frames, k_s - fs_t_s, en_cnt_s);
                    end
                    fs_t_s   = k_s;
                    en_cnt_s = 0;
                end
                if (en_s) en_cnt_s++;
                if (!vs_s && vs_p_s) vs_fall_t_s = k_s;
                if (vs_s && !vs_p_s && vs_fall_t_s >= 0) chk("s_vs_low_len", k_s - vs_fall_t_s, 30);
            end
            fs_p_s = fs_s; vs_p_s = vs_s;
        end

        if (end_chk) begin
            chk("d_lines_measured", (n_lines >= 4) ? 1 : 0, 1);
            chk("s_frames_measured", (n_frames >= 20) ? 1 : 0, 1);
            end_chk = 1'b0;
        end
    end

    initial begin
        @(negedge clk);
        rst_n_d = 1'b0;
        rst_n_s = 1'b0;
        repeat (5) @(negedge clk);
        rst_n_d = 1'b1;
        rst_n_s = 1'b1;
        // Small raster: reset for one clock in the middle of its fourth frame
        repeat (3 * 120 + 50) @(negedge clk);
        rst_n_s = 1'b0;
        @(negedge clk);
        rst_n_s = 1'b1;
        // Default raster: reset for one clock at line 2, pixel 500
        repeat (2 * 1344 + 500 - (3 * 120 + 51)) @(negedge clk);
        rst_n_d = 1'b0;
        @(negedge clk);
        rst_n_d = 1'b1;
        repeat (4 * 1344 + 200) @(negedge clk);
        end_chk = 1'b1;
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
